// File: rtl/asm_datapath.sv
// Datapath stage for the 3-bit ASM controller: working register A, link E,
// sign flag F, captured result with done pulse, and a sticky illegal-control flag.
module asm_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_dec_out,
  input  logic             i_x,
  input  logic             i_y,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_a,
  output logic             o_e,
  output logic             o_f,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_err
);

  logic [WIDTH-1:0] r_a;
  logic             r_e;
  logic             r_f;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_a_nxt;
  logic             w_e_nxt;
  logic             w_a_wr;
  logic             w_term;
  logic             w_illegal;
  logic [WIDTH:0]   w_inc;

  assign w_inc = {1'b0, r_a} + {{WIDTH{1'b0}}, 1'b1};

  // Any dec_out value that is not exactly one-hot lands in the default arm.
  always_comb begin
    w_a_nxt   = r_a;
    w_e_nxt   = r_e;
    w_a_wr    = 1'b0;
    w_term    = 1'b0;
    w_illegal = 1'b0;
    case (i_dec_out)
      8'h80: begin
        if (i_x) begin
          w_a_nxt = '0;
          w_e_nxt = 1'b0;
          w_a_wr  = 1'b1;
        end else if (i_y) begin
          w_a_nxt = i_din;
          w_e_nxt = 1'b0;
          w_a_wr  = 1'b1;
        end
      end
      8'h40: begin
        {w_e_nxt, w_a_nxt} = w_inc;
        w_a_wr = 1'b1;
      end
      8'h20: ;
      8'h10: w_term = 1'b1;
      8'h08: begin
        w_a_nxt = ~r_a;
        w_a_wr  = 1'b1;
      end
      8'h04: begin
        {w_e_nxt, w_a_nxt} = w_inc;
        w_a_wr = 1'b1;
        w_term = 1'b1;
      end
      8'h02, 8'h01: begin
        w_a_nxt = {r_e, r_a[WIDTH-1:1]};
        w_e_nxt = r_a[0];
        w_a_wr  = 1'b1;
        w_term  = (i_dec_out == 8'h01);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_e      <= 1'b0;
      r_f      <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_illegal) begin
        r_err <= 1'b1;
      end else begin
        r_a <= w_a_nxt;
        r_e <= w_e_nxt;
        if (w_a_wr) r_f <= w_a_nxt[WIDTH-1];
        if (w_term) begin
          r_result <= w_a_nxt;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_a      = r_a;
  assign o_e      = r_e;
  assign o_f      = r_f;
  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_asm_datapath.sv
// Directed bench for asm_datapath: a behavioural model pushes expected register
// values per step; they are popped and compared one cycle later.
module tb_asm_datapath;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   dec_out;
  logic         x, y;
  logic [W-1:0] din;
  logic [W-1:0] a, result;
  logic         e, f, done, err;

  asm_datapath #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_dec_out(dec_out), .i_x(x), .i_y(y), .i_din(din),
    .o_a(a), .o_e(e), .o_f(f), .o_result(result), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         e;
    logic         f;
    logic [W-1:0] res;
    logic         done;
    logic         err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] m_a = '0, m_res = '0;
  logic         m_e = 0, m_f = 0, m_done = 0, m_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Model one edge, push the expectation, clock the DUT, then pop and compare.
  task automatic step(input string tag, input logic [7:0] d, input logic xi, input logic yi,
                      input logic [W-1:0] di, input logic ri);
    exp_t ex;
    logic [W:0] sum;
    logic       nb;
    rst = ri; dec_out = d; x = xi; y = yi; din = di;
    if (ri) begin
      m_a = '0; m_e = 0; m_f = 0; m_res = '0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      sum = m_a + 5'd1;
      case (d)
        8'h80: if (xi) begin m_a = '0; m_e = 0; m_f = 0; end
               else if (yi) begin m_a = di; m_e = 0; m_f = di[W-1]; end
        8'h40: begin m_a = sum[W-1:0]; m_e = sum[W]; m_f = m_a[W-1]; end
        8'h20: ;
        8'h10: begin m_res = m_a; m_done = 1; end
        8'h08: begin m_a = ~m_a; m_f = m_a[W-1]; end
        8'h04: begin m_a = sum[W-1:0]; m_e = sum[W]; m_f = m_a[W-1];
                     m_res = m_a; m_done = 1; end
        8'h02, 8'h01: begin
          nb = m_a[0];
          m_a = {m_e, m_a[W-1:1]}; m_e = nb; m_f = m_a[W-1];
          if (d == 8'h01) begin m_res = m_a; m_done = 1; end
        end
        default: m_err = 1;
      endcase
    end
    ex.a = m_a; ex.e = m_e; ex.f = m_f; ex.res = m_res; ex.done = m_done; ex.err = m_err;
    q.push_back(ex);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk({tag, ".A"},      {4'b0, a},      {4'b0, ex.a});
    chk({tag, ".E"},      {7'b0, e},      {7'b0, ex.e});
    chk({tag, ".F"},      {7'b0, f},      {7'b0, ex.f});
    chk({tag, ".result"}, {4'b0, result}, {4'b0, ex.res});
    chk({tag, ".done"},   {7'b0, done},   {7'b0, ex.done});
    chk({tag, ".err"},    {7'b0, err},    {7'b0, ex.err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; dec_out = 8'h20; x = 0; y = 0; din = '0;
    @(negedge clk);
    // 1. reset, after some prior activity
    step("rst0", 8'h20, 0, 0, 4'h0, 1);
    step("pre_ld", 8'h80, 0, 1, 4'hA, 0);
    step("pre_t5", 8'h04, 0, 0, 4'h0, 0);
    step("rst1", 8'h80, 0, 1, 4'h9, 1);
    // 2. clear-and-walk
    step("ld5", 8'h80, 0, 1, 4'h5, 0);
    step("clr", 8'h80, 1, 0, 4'h0, 0);
    step("t1", 8'h40, 0, 0, 4'h0, 0);
    step("t2", 8'h20, 0, 0, 4'h0, 0);
    step("t4", 8'h08, 0, 0, 4'h0, 0);
    step("t6", 8'h02, 0, 0, 4'h0, 0);
    step("t7", 8'h01, 0, 0, 4'h0, 0);
    step("t7_after", 8'h20, 0, 0, 4'h0, 0);
    // 3. load path and x priority
    step("ldF", 8'h80, 0, 1, 4'hF, 0);
    step("ld_t2", 8'h20, 0, 0, 4'h0, 0);
    step("ld_t3", 8'h10, 0, 0, 4'h0, 0);
    step("ld_after", 8'h20, 0, 0, 4'h0, 0);
    step("xy_pri", 8'h80, 1, 1, 4'hF, 0);
    // 4. carry into E via T1 and T5, then back-to-back terminals
    step("c_ld1", 8'h80, 0, 1, 4'hF, 0);
    step("c_t1", 8'h40, 0, 0, 4'h0, 0);
    step("c_ld5", 8'h80, 0, 1, 4'hF, 0);
    step("c_t5", 8'h04, 0, 0, 4'h0, 0);
    step("b2b_t3", 8'h10, 0, 0, 4'h0, 0);
    step("b2b_t5", 8'h04, 0, 0, 4'h0, 0);
    step("b2b_t7", 8'h01, 0, 0, 4'h0, 0);
    // 5. illegal control, sticky err
    step("ill_ld", 8'h80, 0, 1, 4'h9, 0);
    step("ill_t3", 8'h10, 0, 0, 4'h0, 0);
    step("ill_00", 8'h00, 1, 1, 4'h3, 0);
    step("ill_81", 8'h81, 1, 0, 4'h3, 0);
    step("ill_ff", 8'hFF, 0, 0, 4'h0, 0);
    step("resume_t1", 8'h40, 0, 0, 4'h0, 0);
    for (int i = 0; i < 10; i++) step("legal_hold", 8'h20, 0, 0, 4'h0, 0);
    step("err_clr", 8'h20, 0, 0, 4'h0, 1);
    // 6. reset mid-sequence, then T0 hold
    step("m_ld", 8'h80, 0, 1, 4'hB, 0);
    step("m_t1", 8'h40, 0, 0, 4'h0, 0);
    step("m_t6rst", 8'h02, 0, 0, 4'h0, 1);
    step("m_ld2", 8'h80, 0, 1, 4'h6, 0);
    step("t0_hold", 8'h80, 0, 0, 4'hD, 0);
    step("t0_hold2", 8'h80, 0, 0, 4'h1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
